// File: rtl/fib_reader_pkg.sv
// Shared definitions for the Fibonacci RAM read-out block and the RAM/regfile
// controller that uses the same sequencing states.
//   FIB_AW / FIB_DW : default RAM address and data widths
//   fib_state_e     : read-out sequencer state encoding
package fib_reader_pkg;

  localparam int FIB_AW = 6;
  localparam int FIB_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAP  = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4
  } fib_state_e;

endpackage

// File: rtl/fib_reader_check.sv
// Recurrence checker for the Fibonacci read-out: keeps the last two accepted
// words and flags any word (address >= 2) that is not their sum mod 2^DW.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear_i          start of a new pass: drop history and error state
//   acc_i            a word is being accepted by the consumer this cycle
//   data_i, addr_i   the word being accepted and its RAM address
//   err_o            sticky mismatch flag for the current pass
//   err_addr_o       address of the first mismatch in the pass
module fib_check
  import fib_reader_pkg::*;
#(
  parameter int AW = FIB_AW,
  parameter int DW = FIB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          acc_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] addr_i,
  output logic          err_o,
  output logic [AW-1:0] err_addr_o
);

  logic [DW-1:0] p1_q;   // most recent accepted word
  logic [DW-1:0] p2_q;   // word before that
  logic          err_q;
  logic [AW-1:0] err_addr_q;
  logic [DW-1:0] sum;
  logic          checked;
  logic          mismatch;

  // Sum truncates to DW bits, giving the mod 2^DW recurrence directly.
  assign sum      = p1_q + p2_q;
  // Addresses 0 and 1 are seeds: any upper address bit set means addr >= 2.
  assign checked  = |addr_i[AW-1:1];
  assign mismatch = acc_i && checked && (data_i != sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q       <= '0;
      p2_q       <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (clear_i) begin
      p1_q       <= '0;
      p2_q       <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (acc_i) begin
      p2_q <= p1_q;
      p1_q <= data_i;
      if (mismatch) begin
        err_q <= 1'b1;
        // Only the first mismatch of a pass records its address.
        if (!err_q) err_addr_q <= addr_i;
      end
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: rtl/fib_reader.sv
// Reads RAM addresses 0..LAST once per start request, presents each word on a
// valid/ready output port and checks the Fibonacci recurrence on the stream.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request to begin a pass (IDLE only)
//   busy, done            pass in progress / one-cycle completion pulse
//   ram_ra, ram_rd        RAM read address; data returns one cycle later
//   out_valid, out_ready  output handshake
//   out_data, out_addr    word read and its RAM address
//   err, err_addr         sticky recurrence mismatch and first failing address
module fib_reader
  import fib_reader_pkg::*;
#(
  parameter int AW   = FIB_AW,
  parameter int DW   = FIB_DW,
  parameter int LAST = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  localparam logic [AW-1:0] LAST_A = AW'(LAST);

  fib_state_e    state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] ram_ra_q;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          start_acc;
  logic          hs;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign hs        = (state_q == ST_SEND) && out_valid_q && out_ready;
  assign addr_d    = addr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      ram_ra_q    <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= '0;
            ram_ra_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_REQ;
          end
        end
        // ram_ra already holds the address; the RAM samples it this cycle.
        ST_REQ: state_q <= ST_CAP;
        ST_CAP: begin
          out_data_q  <= ram_rd;
          out_addr_q  <= addr_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            if (addr_q < LAST_A) begin
              addr_q   <= addr_d;
              ram_ra_q <= addr_d;
              state_q  <= ST_REQ;
            end else begin
              // busy drops in the same cycle that done is high.
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fib_check #(
    .AW(AW),
    .DW(DW)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (start_acc),
    .acc_i     (hs),
    .data_i    (out_data_q),
    .addr_i    (out_addr_q),
    .err_o     (err),
    .err_addr_o(err_addr)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_ra    = ram_ra_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_fib_reader.sv
// Bench for fib_reader: a LAST=63 instance driven from a table of RAM images
// and ready patterns, plus hand-written sequences for error timing, start
// filtering, mid-pass reset, and a LAST=2 instance for the wrap-around sum.
module tb_fib_reader;

  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A (LAST = 63) ----------------
  logic          startA = 1'b0, rdyA = 1'b1;
  logic          busyA, doneA, vA, errA;
  logic [AW-1:0] raA, oaA, eaA;
  logic [DW-1:0] rdA = '0, odA;
  logic [DW-1:0] memA [64];
  bit            rnd_rdy = 1'b0;

  fib_reader #(.AW(AW), .DW(DW), .LAST(63)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .busy(busyA), .done(doneA),
    .ram_ra(raA), .ram_rd(rdA), .out_valid(vA), .out_ready(rdyA),
    .out_data(odA), .out_addr(oaA), .err(errA), .err_addr(eaA));

  always @(posedge clk) rdA <= memA[raA];

  always @(posedge clk) begin
    #1;
    rdyA = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // ---------------- DUT B (LAST = 2) ----------------
  logic          startB = 1'b0, rdyB = 1'b1;
  logic          busyB, doneB, vB, errB;
  logic [AW-1:0] raB, oaB, eaB;
  logic [DW-1:0] rdB = '0, odB;
  logic [DW-1:0] memB [64];

  fib_reader #(.AW(AW), .DW(DW), .LAST(2)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .busy(busyB), .done(doneB),
    .ram_ra(raB), .ram_rd(rdB), .out_valid(vB), .out_ready(rdyB),
    .out_data(odB), .out_addr(oaB), .err(errB), .err_addr(eaB));

  always @(posedge clk) rdB <= memB[raB];

  // ---------------- monitors (sample on falling edge) ----------------
  logic [DW-1:0] qd[$];
  logic [AW-1:0] qa[$];
  int            qc[$];
  int            stall_bad = 0, done_cnt = 0, busy_bad = 0;
  logic          stall_pend = 1'b0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        if (!vA || odA !== hold_d || oaA !== hold_a) stall_bad++;
      end
      if (vA && rdyA) begin
        qd.push_back(odA);
        qa.push_back(oaA);
        qc.push_back(cyc);
      end
      stall_pend = vA && !rdyA;
      hold_d = odA;
      hold_a = oaA;
      if (doneA) begin
        done_cnt++;
        if (busyA) busy_bad++;
      end
    end
  end

  logic [DW-1:0] qdB[$];
  logic [AW-1:0] qaB[$];
  int            done_cntB = 0, rab_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (vB && rdyB) begin
        qdB.push_back(odB);
        qaB.push_back(oaB);
      end
      if (doneB) done_cntB++;
      if (raB > 6'd2) rab_bad++;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic void load_fib();
    memA[0] = 32'd1;
    memA[1] = 32'd1;
    for (int i = 2; i < 64; i++) memA[i] = memA[i-1] + memA[i-2];
  endfunction

  // Reference: first index >= 2 whose word is not the 32-bit sum of the two before.
  task automatic model_err(output logic e, output int ea);
    logic [DW-1:0] s;
    e = 1'b0;
    ea = 0;
    for (int i = 2; i <= 63; i++) begin
      s = memA[i-1] + memA[i-2];
      if (memA[i] != s) begin
        if (!e) ea = i;
        e = 1'b1;
      end
    end
  endtask

  function automatic void clear_mon();
    qd.delete();
    qa.delete();
    qc.delete();
    stall_bad = 0;
    done_cnt = 0;
    busy_bad = 0;
  endfunction

  task automatic pulse_startA();
    @(posedge clk); #1 startA = 1'b1;
    @(posedge clk); #1 startA = 1'b0;
  endtask

  task automatic wait_doneA(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt != 0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_words();
    int wbad;
    logic [AW-1:0] ea;
    wbad = 0;
    chk("n_words", qd.size(), 64);
    for (int i = 0; i < qd.size() && i < 64; i++) begin
      ea = AW'(i);
      if (qd[i] !== memA[i] || qa[i] !== ea) wbad++;
    end
    chk("word_seq", wbad, 0);
  endtask

  task automatic wait_hs_addr(input logic [AW-1:0] a, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(vA && rdyA && oaA == a) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < 1000, 1'b1);
  endtask

  typedef struct {
    int            fa;      // faulted address, -1 for none
    logic [DW-1:0] fv;      // value placed there
    bit            rnd;     // random out_ready
    logic          exp_err;
    int            exp_ea;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic me;
    int   mea;
    int   sp;
    int   sz;

    tbl[0] = '{-1, 32'd0,     1'b0, 1'b0, 0};
    tbl[1] = '{-1, 32'd0,     1'b1, 1'b0, 0};
    tbl[2] = '{5,  32'd9,     1'b0, 1'b1, 5};
    tbl[3] = '{20, 32'd12345, 1'b1, 1'b1, 20};

    load_fib();
    for (int i = 0; i < 64; i++) memB[i] = 32'hDEAD_0000 + i;
    memB[0] = 32'hFFFF_FFFF;
    memB[1] = 32'd1;
    memB[2] = 32'd0;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busyA, 1'b0);
    chk("rst_done", doneA, 1'b0);
    chk("rst_valid", vA, 1'b0);
    chk("rst_data", odA, 0);
    chk("rst_addr", oaA, 0);
    chk("rst_err", {errA, eaA}, 0);
    chk("rst_ra", raA, 0);
    chk("rst_b_outs", {busyB, doneB, vB, odB, oaB, errB, eaB, raB}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- table of full passes ----------------
    for (int t = 0; t < 4; t++) begin
      load_fib();
      if (tbl[t].fa >= 0) memA[tbl[t].fa] = tbl[t].fv;
      rnd_rdy = tbl[t].rnd;
      clear_mon();
      pulse_startA();
      wait_doneA(3000);
      rnd_rdy = 1'b0;
      check_words();
      model_err(me, mea);
      chk("err_model", errA, me);
      chk("err_table", errA, tbl[t].exp_err);
      chk("eaddr_model", eaA, mea);
      chk("eaddr_table", eaA, tbl[t].exp_ea);
      chk("done_count", done_cnt, 1);
      chk("stall_stable", stall_bad, 0);
      chk("busy_at_done", busy_bad, 0);
      chk("busy_idle", busyA, 1'b0);
      if (!tbl[t].rnd) begin
        sp = 0;
        for (int i = 1; i < qc.size(); i++) if (qc[i] - qc[i-1] != 3) sp++;
        chk("spacing3", sp, 0);
      end
    end

    // ---------------- error timing at address 5 ----------------
    load_fib();
    memA[5] = 32'd9;
    clear_mon();
    pulse_startA();
    wait_hs_addr(6'd5, "hs5_seen");
    chk("err_before5", errA, 1'b0);
    @(negedge clk);
    chk("err_after5", errA, 1'b1);
    chk("eaddr_after5", eaA, 5);
    wait_hs_addr(6'd7, "hs7_seen");
    @(negedge clk);
    chk("eaddr_after7", eaA, 5);
    wait_doneA(3000);

    // ---------------- start while busy, in FIN, and after done ----------------
    load_fib();
    clear_mon();
    pulse_startA();
    repeat (20) @(negedge clk);
    startA = 1'b1;
    repeat (2) @(negedge clk);
    startA = 1'b0;
    repeat (30) @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    sp = 0;
    while (!doneA && sp < 3000) begin
      @(negedge clk);
      sp++;
    end
    chk("fin_reached", doneA, 1'b1);
    chk("err_cleared", errA, 1'b0);
    startA = 1'b1;               // present during the FIN cycle
    @(negedge clk);
    chk("fin_start_ignored", busyA, 1'b0);
    @(negedge clk);              // still high in the cycle after done
    startA = 1'b0;
    chk("after_done_start", busyA, 1'b1);
    wait_doneA(3000);
    while (done_cnt < 2 && sp < 6000) begin
      @(negedge clk);
      sp++;
    end
    repeat (3) @(negedge clk);
    chk("two_dones", done_cnt, 2);
    chk("two_pass_words", qd.size(), 128);
    if (qa.size() > 64) chk("pass2_addr0", qa[64], 0);

    // ---------------- reset mid-pass ----------------
    load_fib();
    memA[3] = 32'd7;
    clear_mon();
    pulse_startA();
    wait_hs_addr(6'd10, "hs10_seen");
    @(posedge clk); #2;
    chk("err_pre_rst", errA, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {busyA, doneA, vA, errA}, 0);
    chk("arst_data", {odA, oaA, eaA, raA}, 0);
    chk("arst_hist", {dutA.u_chk.p1_q, dutA.u_chk.p2_q}, 0);
    sz = qd.size();
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_words_after_rst", qd.size(), sz);
    chk("no_done_after_rst", done_cnt, 0);
    load_fib();
    clear_mon();
    pulse_startA();
    wait_doneA(3000);
    check_words();
    chk("err_after_rst_pass", errA, 1'b0);

    // ---------------- LAST = 2, 32-bit wrap ----------------
    @(posedge clk); #1 startB = 1'b1;
    @(posedge clk); #1 startB = 1'b0;
    sp = 0;
    while (done_cntB == 0 && sp < 200) begin
      @(negedge clk);
      sp++;
    end
    repeat (3) @(negedge clk);
    chk("b_done", done_cntB, 1);
    chk("b_words", qdB.size(), 3);
    if (qdB.size() == 3) begin
      chk("b_w0", {qaB[0], qdB[0]}, {6'd0, 32'hFFFF_FFFF});
      chk("b_w1", {qaB[1], qdB[1]}, {6'd1, 32'd1});
      chk("b_w2", {qaB[2], qdB[2]}, {6'd2, 32'd0});
    end
    chk("b_err", errB, 1'b0);
    chk("b_ra_bound", rab_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
